// File: rtl/calc_pkg.sv
// Shared constants for the calculator datapath: default operand width and
// the state encoding used by the serial arithmetic sequencer.
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef logic [1:0] calc_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/half_add_cell.sv
// One-bit half adder; two of these plus an OR form the serial full adder.
module half_add_cell (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; operands latched when it is seen
//   ST_SHIFT | one full-add per clock, carry kept in carry_q
//   ST_DONE  | one-cycle done pulse, outputs already valid
module serial_add_unit
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    calc_state_t      state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic ha0_sum, ha0_carry, fa_sum, ha1_carry, fa_co;

    half_add_cell u_ha0 (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .sum   (ha0_sum),
        .carry (ha0_carry)
    );

    half_add_cell u_ha1 (
        .a     (ha0_sum),
        .b     (carry_q),
        .sum   (fa_sum),
        .carry (ha1_carry)
    );

    assign fa_co = ha0_carry | ha1_carry;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        part_d   = part_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtraction is A + ~B + 1: invert B here, seed carry with sub.
                    a_d     = op_a;
                    b_d     = op_b ^ {WIDTH{sub}};
                    part_d  = '0;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                part_d  = {fa_sum, part_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    result_d = part_d;
                    cout_d   = fa_co;
                    ovf_d    = carry_q ^ fa_co;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            part_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            part_q   <= part_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy   = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_unit.sv
// Scoreboard bench for serial_add_unit: directed cases plus random ops at
// WIDTH=8 and WIDTH=16 against an arithmetic reference model.
module tb_serial_add_unit;

    typedef struct {
        logic [15:0] res;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] op_a8 = '0, op_b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] result8;

    logic        start16 = 1'b0, sub16 = 1'b0;
    logic [15:0] op_a16 = '0, op_b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] result16;

    serial_add_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8),
        .op_a(op_a8), .op_b(op_b8), .busy(busy8), .done(done8),
        .result(result8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_unit #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16),
        .op_a(op_a16), .op_b(op_b16), .busy(busy16), .done(done16),
        .result(result16), .cout(cout16), .ovf(ovf16)
    );

    // Reference: plain (A + B) or (A + ~B + 1) in W+1 bits; overflow from sign rule.
    function automatic exp_t model(input int w, input logic [15:0] a,
                                   input logic [15:0] b, input logic s);
        exp_t        e;
        logic [16:0] mask, aa, bb, sum;
        mask  = (17'd1 << w) - 17'd1;
        aa    = {1'b0, a} & mask;
        bb    = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
        sum   = aa + bb + {16'd0, s};
        e.res  = sum[15:0] & mask[15:0];
        e.cout = sum[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
        return e;
    endfunction

    task automatic start_op8(input logic [7:0] a, input logic [7:0] b,
                             input logic s, input bit push);
        @(negedge clk);
        op_a8 = a; op_b8 = b; sub8 = s; start8 = 1'b1;
        if (push) sb_q.push_back(model(8, {8'h00, a}, {8'h00, b}, s));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic start_op16(input logic [15:0] a, input logic [15:0] b, input logic s);
        @(negedge clk);
        op_a16 = a; op_b16 = b; sub16 = s; start16 = 1'b1;
        sb_q.push_back(model(16, a, b, s));
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_done8(output int edges);
        edges = 0;
        while (done8 !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        if (done8 !== 1'b1) edges = -1;
    endtask

    task automatic wait_done16(output int edges);
        edges = 0;
        while (done16 !== 1'b1 && edges < 60) begin
            @(negedge clk);
            edges++;
        end
        if (done16 !== 1'b1) edges = -1;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++;
        if ({busy8, done8, cout8, ovf8, result8} !== 12'h000) begin
            n_err++;
            $display("FAIL reset8: busy=%b done=%b cout=%b ovf=%b result=%h, required all 0",
                     busy8, done8, cout8, ovf8, result8);
        end
        n_cmp++;
        if ({busy16, done16, cout16, ovf16, result16} !== 20'h00000) begin
            n_err++;
            $display("FAIL reset16: busy=%b done=%b result=%h, required all 0",
                     busy16, done16, result16);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic;
        int   e;
        exp_t x;
        start_op8(8'h3C, 8'h05, 1'b0, 1'b1);
        n_cmp++;
        if (busy8 !== 1'b1) begin
            n_err++;
            $display("FAIL busy_in_shift: busy=%b, required 1", busy8);
        end
        wait_done8(e);
        n_cmp++;
        if (e !== 8) begin
            n_err++;
            $display("FAIL latency: done after %0d edges, required 8", e);
        end
        x = sb_q.pop_front();
        n_cmp++;
        if (result8 !== 8'h41 || result8 !== x.res[7:0] || cout8 !== x.cout || ovf8 !== x.ovf) begin
            n_err++;
            $display("FAIL add_3c_05: result=%h cout=%b ovf=%b, required %h %b %b",
                     result8, cout8, ovf8, x.res[7:0], x.cout, x.ovf);
        end
        @(negedge clk);
        n_cmp++;
        if (done8 !== 1'b0) begin
            n_err++;
            $display("FAIL done_pulse_width: done=%b one cycle later, required 0", done8);
        end
    endtask

    task automatic test_add_edges;
        int   e;
        exp_t x;
        start_op8(8'hFF, 8'h01, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (result8 !== 8'h41) begin
            n_err++;
            $display("FAIL result_hold: result=%h mid-shift, required 41", result8);
        end
        wait_done8(e);
        n_cmp++;
        if (e !== 5) begin
            n_err++;
            $display("FAIL latency_ff01: %0d further edges, required 5", e);
        end
        x = sb_q.pop_front();
        n_cmp++;
        if (result8 !== x.res[7:0] || cout8 !== x.cout || ovf8 !== x.ovf) begin
            n_err++;
            $display("FAIL add_ff_01: result=%h cout=%b ovf=%b, required %h %b %b",
                     result8, cout8, ovf8, x.res[7:0], x.cout, x.ovf);
        end
        start_op8(8'h7F, 8'h01, 1'b0, 1'b1);
        wait_done8(e);
        x = sb_q.pop_front();
        n_cmp++;
        if (e !== 8 || result8 !== 8'h80 || cout8 !== x.cout || ovf8 !== 1'b1) begin
            n_err++;
            $display("FAIL add_7f_01: edges=%0d result=%h cout=%b ovf=%b, required 8 80 %b 1",
                     e, result8, cout8, ovf8, x.cout);
        end
    endtask

    task automatic test_sub;
        logic [7:0] av [2] = '{8'h05, 8'h80};
        logic [7:0] bv [2] = '{8'h07, 8'h01};
        int   e;
        exp_t x;
        for (int i = 0; i < 2; i++) begin
            start_op8(av[i], bv[i], 1'b1, 1'b1);
            wait_done8(e);
            x = sb_q.pop_front();
            n_cmp++;
            if (e !== 8 || result8 !== x.res[7:0] || cout8 !== x.cout || ovf8 !== x.ovf) begin
                n_err++;
                $display("FAIL sub_%h_%h: edges=%0d result=%h cout=%b ovf=%b, required 8 %h %b %b",
                         av[i], bv[i], e, result8, cout8, ovf8, x.res[7:0], x.cout, x.ovf);
            end
        end
    endtask

    task automatic test_back_to_back;
        int   e, gap;
        exp_t x;
        @(negedge clk);
        op_a8 = 8'h10; op_b8 = 8'h20; sub8 = 1'b0; start8 = 1'b1;
        sb_q.push_back(model(8, 16'h0010, 16'h0020, 1'b0));
        @(negedge clk);
        op_a8 = 8'hC3; op_b8 = 8'h5A; sub8 = 1'b1;
        sb_q.push_back(model(8, 16'h00C3, 16'h005A, 1'b1));
        wait_done8(e);
        x = sb_q.pop_front();
        n_cmp++;
        if (e !== 8 || result8 !== x.res[7:0] || cout8 !== x.cout || ovf8 !== x.ovf) begin
            n_err++;
            $display("FAIL b2b_first: edges=%0d result=%h cout=%b ovf=%b, required 8 %h %b %b",
                     e, result8, cout8, ovf8, x.res[7:0], x.cout, x.ovf);
        end
        gap = 0;
        repeat (2) begin
            @(negedge clk);
            gap++;
        end
        start8 = 1'b0;
        while (done8 !== 1'b1 && gap < 40) begin
            @(negedge clk);
            gap++;
        end
        n_cmp++;
        if (gap !== 10) begin
            n_err++;
            $display("FAIL b2b_spacing: %0d cycles between done pulses, required 10", gap);
        end
        x = sb_q.pop_front();
        n_cmp++;
        if (result8 !== x.res[7:0] || cout8 !== x.cout || ovf8 !== x.ovf) begin
            n_err++;
            $display("FAIL b2b_second: result=%h cout=%b ovf=%b, required %h %b %b",
                     result8, cout8, ovf8, x.res[7:0], x.cout, x.ovf);
        end
    endtask

    task automatic test_ignore_start;
        int   e;
        exp_t x;
        start_op8(8'h21, 8'h13, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        op_a8 = 8'hFF; op_b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(e);
        x = sb_q.pop_front();
        n_cmp++;
        if (e !== 4 || result8 !== 8'h34 || cout8 !== x.cout || ovf8 !== x.ovf) begin
            n_err++;
            $display("FAIL ignore_start: edges=%0d result=%h cout=%b ovf=%b, required 4 34 %b %b",
                     e, result8, cout8, ovf8, x.cout, x.ovf);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy8 !== 1'b0) begin
            n_err++;
            $display("FAIL no_queue: busy=%b after done, required 0", busy8);
        end
    endtask

    task automatic test_reset_mid;
        int   e;
        bit   seen;
        exp_t x;
        start_op8(8'h3C, 8'h05, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy8, done8, cout8, ovf8, result8} !== 12'h000) begin
            n_err++;
            $display("FAIL async_abort: busy=%b done=%b cout=%b ovf=%b result=%h, required all 0",
                     busy8, done8, cout8, ovf8, result8);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: done seen=%b, required 0", seen);
        end
        rst_n = 1'b1;
        start_op8(8'h01, 8'h01, 1'b0, 1'b1);
        wait_done8(e);
        x = sb_q.pop_front();
        n_cmp++;
        if (e !== 8 || result8 !== 8'h02 || cout8 !== x.cout || ovf8 !== x.ovf) begin
            n_err++;
            $display("FAIL after_reset: edges=%0d result=%h cout=%b ovf=%b, required 8 02 0 0",
                     e, result8, cout8, ovf8);
        end
    endtask

    task automatic test_random8;
        int   e;
        exp_t x;
        for (int i = 0; i < 1000; i++) begin
            start_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            wait_done8(e);
            x = sb_q.pop_front();
            n_cmp++;
            if (e !== 8 || result8 !== x.res[7:0] || cout8 !== x.cout || ovf8 !== x.ovf) begin
                n_err++;
                $display("FAIL rand8 #%0d: a=%h b=%h sub=%b edges=%0d got %h %b %b, required %h %b %b",
                         i, op_a8, op_b8, sub8, e, result8, cout8, ovf8, x.res[7:0], x.cout, x.ovf);
            end
        end
    endtask

    task automatic test_random16;
        int   e;
        exp_t x;
        for (int i = 0; i < 1000; i++) begin
            start_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
            wait_done16(e);
            x = sb_q.pop_front();
            n_cmp++;
            if (e !== 16 || result16 !== x.res || cout16 !== x.cout || ovf16 !== x.ovf) begin
                n_err++;
                $display("FAIL rand16 #%0d: a=%h b=%h sub=%b edges=%0d got %h %b %b, required %h %b %b",
                         i, op_a16, op_b16, sub16, e, result16, cout16, ovf16, x.res, x.cout, x.ovf);
            end
        end
    endtask

    initial begin
        test_reset;
        test_add_basic;
        test_add_edges;
        test_sub;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        test_random8;
        test_random16;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
